// File: rtl/fsmc_rd_pkg.sv
// Shared constants for the FSMC read-back slave: register map, ID value,
// CTRL bit positions and the bus FSM state encoding.
package fsmc_rd_pkg;

  // Register map
  localparam int unsigned ADDR_DATA    = 0;
  localparam int unsigned ADDR_LEVEL   = 1;
  localparam int unsigned ADDR_STATUS  = 2;
  localparam int unsigned ADDR_CTRL    = 3;
  localparam int unsigned ADDR_ID      = 4;
  localparam int unsigned ADDR_SCRATCH = 5;

  localparam logic [15:0] ID_VALUE = 16'h23A5;

  // CTRL register bits; flush and ovf_clr are write-only strobes
  localparam int unsigned CTRL_CAPTURE_BIT = 0;
  localparam int unsigned CTRL_FLUSH_BIT   = 1;
  localparam int unsigned CTRL_OVF_CLR_BIT = 2;

  // Bus FSM state encoding
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 256
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  // Pointer and level bookkeeping; flush overrides any push/pop
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge sys_clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/fsmc_rd_slave.sv
// FSMC 16-bit asynchronous bus responder: buffers the sample stream in a FIFO
// and exposes DATA/LEVEL/STATUS/CTRL/ID registers to the MCU.
// Optional: define FSMC_RD_LOOPBACK_EN to add a scratch register at address 5.
module fsmc_rd_slave
  import fsmc_rd_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [15:0]       smp_data,
  input  logic              smp_valid,
  input  logic              fsmc_ne,
  input  logic              fsmc_noe,
  input  logic              fsmc_nwe,
  input  logic [ADDR_W-1:0] fsmc_a,
  input  logic [15:0]       fsmc_db_i,
  output logic [15:0]       fsmc_db_o,
  output logic              fsmc_db_oe,
  output logic              capture_en,
  output logic              fifo_ovf
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [1:0]        ne_sync_q, noe_sync_q, nwe_sync_q;
  logic              ne_s, noe_s, nwe_s;
  logic [1:0]        state_q, state_d;
  logic              rd_enter, rd_exit, wr_exit;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q, dout_q, rd_data;
  logic              oe_q, capture_en_q, ovf_q;
  logic              ctrl_wr, flush, ovf_clr, push, pop, overflow;
  logic [15:0]       fifo_dout;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_full, fifo_empty;

  // Two-stage synchronizers; bus strobes idle high
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      ne_sync_q  <= 2'b11;
      noe_sync_q <= 2'b11;
      nwe_sync_q <= 2'b11;
    end else begin
      ne_sync_q  <= {ne_sync_q[0], fsmc_ne};
      noe_sync_q <= {noe_sync_q[0], fsmc_noe};
      nwe_sync_q <= {nwe_sync_q[0], fsmc_nwe};
    end
  end

  assign ne_s  = ne_sync_q[1];
  assign noe_s = noe_sync_q[1];
  assign nwe_s = nwe_sync_q[1];

  // Bus FSM next state and transition strobes; read wins over write
  always_comb begin
    state_d  = state_q;
    rd_enter = 1'b0;
    rd_exit  = 1'b0;
    wr_exit  = 1'b0;
    case (state_q)
      StIdle: begin
        if (!ne_s && !noe_s) begin
          state_d  = StRead;
          rd_enter = 1'b1;
        end else if (!ne_s && !nwe_s) begin
          state_d = StWrite;
        end
      end
      StRead: begin
        if (ne_s || noe_s) begin
          state_d = StIdle;
          rd_exit = 1'b1;
        end
      end
      StWrite: begin
        if (ne_s || nwe_s) begin
          state_d = StIdle;
          wr_exit = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef FSMC_RD_LOOPBACK_EN
  logic [15:0] scratch_q;

  // Bring-up scratch register
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch_q <= '0;
    end else if (wr_exit && addr_q == ADDR_W'(ADDR_SCRATCH)) begin
      scratch_q <= wdata_q;
    end
  end
`else
  logic unused_wdata;
  assign unused_wdata = ^wdata_q[15:3];
`endif

  // Read source selection on the live address, sampled on READ entry
  always_comb begin
    rd_data = '0;
    if (fsmc_a == ADDR_W'(ADDR_DATA)) begin
      rd_data = fifo_empty ? 16'h0000 : fifo_dout;
    end else if (fsmc_a == ADDR_W'(ADDR_LEVEL)) begin
      rd_data = 16'(fifo_level);
    end else if (fsmc_a == ADDR_W'(ADDR_STATUS)) begin
      rd_data = {13'b0, ovf_q, fifo_full, fifo_empty};
    end else if (fsmc_a == ADDR_W'(ADDR_CTRL)) begin
      rd_data = {15'b0, capture_en_q};
    end else if (fsmc_a == ADDR_W'(ADDR_ID)) begin
      rd_data = ID_VALUE;
`ifdef FSMC_RD_LOOPBACK_EN
    end else if (fsmc_a == ADDR_W'(ADDR_SCRATCH)) begin
      rd_data = scratch_q;
`endif
    end
  end

  // Commit-time strobes and FIFO control
  always_comb begin
    ctrl_wr  = wr_exit && (addr_q == ADDR_W'(ADDR_CTRL));
    flush    = ctrl_wr && wdata_q[CTRL_FLUSH_BIT];
    ovf_clr  = ctrl_wr && wdata_q[CTRL_OVF_CLR_BIT];
    pop      = rd_exit && (addr_q == ADDR_W'(ADDR_DATA)) && !fifo_empty;
    push     = smp_valid && capture_en_q;
    // A simultaneous pop makes room; a flush discards the word anyway
    overflow = push && fifo_full && !pop && !flush;
  end

  // Bus-side state and registers
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      dout_q       <= '0;
      oe_q         <= 1'b0;
      capture_en_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      oe_q    <= (state_d == StRead);
      if (state_q == StIdle && state_d != StIdle) addr_q <= fsmc_a;
      if (state_q == StWrite) wdata_q <= fsmc_db_i;
      if (rd_enter) dout_q <= rd_data;
      if (ctrl_wr) capture_en_q <= wdata_q[CTRL_CAPTURE_BIT];
      if (overflow) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .push    (push),
    .din     (smp_data),
    .pop     (pop),
    .flush   (flush),
    .dout    (fifo_dout),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign fsmc_db_o  = dout_q;
  assign fsmc_db_oe = oe_q;
  assign capture_en = capture_en_q;
  assign fifo_ovf   = ovf_q;

endmodule

// File: tb/tb_fsmc_rd_slave.sv
// Self-checking bench for fsmc_rd_slave: transaction-level model (queue FIFO,
// CTRL/ovf/scratch state) checked every cycle, plus literal expectations.
module tb_fsmc_rd_slave;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;

  logic              sys_clk = 1'b0;
  logic              rst_n;
  logic [15:0]       smp_data;
  logic              smp_valid;
  logic              fsmc_ne, fsmc_noe, fsmc_nwe;
  logic [ADDR_W-1:0] fsmc_a;
  logic [15:0]       fsmc_db_i;
  logic [15:0]       fsmc_db_o;
  logic              fsmc_db_oe;
  logic              capture_en;
  logic              fifo_ovf;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [15:0] m_q[$];
  bit          m_cap, m_ovf, m_oe, mdl_on;
  logic [15:0] m_dout, m_scr;

  fsmc_rd_slave #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .smp_data   (smp_data),
    .smp_valid  (smp_valid),
    .fsmc_ne    (fsmc_ne),
    .fsmc_noe   (fsmc_noe),
    .fsmc_nwe   (fsmc_nwe),
    .fsmc_a     (fsmc_a),
    .fsmc_db_i  (fsmc_db_i),
    .fsmc_db_o  (fsmc_db_o),
    .fsmc_db_oe (fsmc_db_oe),
    .capture_en (capture_en),
    .fifo_ovf   (fifo_ovf)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge sys_clk) begin
    if (mdl_on) begin
      chk("db_oe", 16'(fsmc_db_oe), 16'(m_oe));
      chk("db_o", fsmc_db_o, m_dout);
      chk("capture_en", 16'(capture_en), 16'(m_cap));
      chk("fifo_ovf", 16'(fifo_ovf), 16'(m_ovf));
    end
  end

  function automatic logic [15:0] model_read(input int unsigned a);
    case (a)
      0:       return (m_q.size() > 0) ? m_q[0] : 16'h0000;
      1:       return 16'(m_q.size());
      2:       return {13'b0, m_ovf, (m_q.size() == DEPTH), (m_q.size() == 0)};
      3:       return {15'b0, m_cap};
      4:       return 16'h23A5;
`ifdef FSMC_RD_LOOPBACK_EN
      5:       return m_scr;
`endif
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_push(input logic [15:0] d);
    if (m_cap) begin
      if (m_q.size() == DEPTH) m_ovf = 1'b1;
      else m_q.push_back(d);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cap  = 1'b0;
    m_ovf  = 1'b0;
    m_oe   = 1'b0;
    m_dout = 16'h0000;
    m_scr  = 16'h0000;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] d);
    smp_data  = d;
    smp_valid = 1'b1;
    tick(1);
    smp_valid = 1'b0;
    model_push(d);
  endtask

  // Bus read; optionally pulse smp_valid on the edge that ends the read
  task automatic read_bus(input int unsigned a, input bit push_end, input logic [15:0] pd,
                          output logic [15:0] got);
    logic [15:0] exp;
    exp      = model_read(a);
    fsmc_a   = ADDR_W'(a);
    fsmc_ne  = 1'b0;
    fsmc_noe = 1'b0;
    tick(3);
    m_oe   = 1'b1;
    m_dout = exp;
    tick(2);
    got      = fsmc_db_o;
    fsmc_noe = 1'b1;
    fsmc_ne  = 1'b1;
    tick(2);
    if (push_end) begin
      smp_data  = pd;
      smp_valid = 1'b1;
    end
    tick(1);
    smp_valid = 1'b0;
    m_oe      = 1'b0;
    if (a == 0 && m_q.size() > 0) void'(m_q.pop_front());
    if (push_end) model_push(pd);
    tick(3);
  endtask

  // Bus write; optionally pulse smp_valid on the commit edge
  task automatic write_bus(input int unsigned a, input logic [15:0] d, input bit push_end,
                           input logic [15:0] pd);
    bit preq, is_ctrl, fl, clr, oset;
    fsmc_a    = ADDR_W'(a);
    fsmc_db_i = d;
    fsmc_ne   = 1'b0;
    fsmc_nwe  = 1'b0;
    tick(5);
    fsmc_nwe = 1'b1;
    fsmc_ne  = 1'b1;
    tick(2);
    if (push_end) begin
      smp_data  = pd;
      smp_valid = 1'b1;
    end
    tick(1);
    smp_valid = 1'b0;
    preq    = push_end && m_cap;
    is_ctrl = (a == 3);
    fl      = is_ctrl && d[1];
    clr     = is_ctrl && d[2];
    oset    = preq && !fl && (m_q.size() == DEPTH);
    if (fl) m_q.delete();
    else if (preq && m_q.size() < DEPTH) m_q.push_back(pd);
    if (oset) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (is_ctrl) m_cap = d[0];
`ifdef FSMC_RD_LOOPBACK_EN
    if (a == 5) m_scr = d;
`endif
    tick(3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] v;
    logic [15:0] scr_exp;
`ifdef FSMC_RD_LOOPBACK_EN
    scr_exp = 16'h1234;
`else
    scr_exp = 16'h0000;
`endif
    mdl_on    = 1'b0;
    model_reset();
    rst_n     = 1'b0;
    smp_data  = '0;
    smp_valid = 1'b0;
    fsmc_ne   = 1'b1;
    fsmc_noe  = 1'b1;
    fsmc_nwe  = 1'b1;
    fsmc_a    = '0;
    fsmc_db_i = '0;
    tick(3);
    chk("rst_db_oe", 16'(fsmc_db_oe), 16'h0);
    chk("rst_db_o", fsmc_db_o, 16'h0);
    chk("rst_capture_en", 16'(capture_en), 16'h0);
    chk("rst_fifo_ovf", 16'(fifo_ovf), 16'h0);
    rst_n = 1'b1;
    tick(2);
    mdl_on = 1'b1;

    // ID and idle status
    read_bus(4, 1'b0, 16'h0, v); chk("id", v, 16'h23A5);
    read_bus(2, 1'b0, 16'h0, v); chk("status_reset", v, 16'h0001);
    push_word(16'hDEAD);  // capture off: ignored
    read_bus(1, 1'b0, 16'h0, v); chk("level_capture_off", v, 16'h0000);

    // Basic ordering
    write_bus(3, 16'h0001, 1'b0, 16'h0);
    read_bus(3, 1'b0, 16'h0, v); chk("ctrl_rd", v, 16'h0001);
    for (int i = 1; i <= 5; i++) push_word(16'(i));
    read_bus(1, 1'b0, 16'h0, v); chk("level_5", v, 16'h0005);
    for (int i = 1; i <= 5; i++) begin
      read_bus(0, 1'b0, 16'h0, v); chk("data_seq", v, 16'(i));
    end
    read_bus(1, 1'b0, 16'h0, v); chk("level_0", v, 16'h0000);
    read_bus(0, 1'b0, 16'h0, v); chk("data_empty", v, 16'h0000);
    read_bus(1, 1'b0, 16'h0, v); chk("level_after_empty_rd", v, 16'h0000);

    // Overfill
    for (int i = 0; i < DEPTH + 2; i++) push_word(16'h0100 + 16'(i));
    read_bus(1, 1'b0, 16'h0, v); chk("level_full", v, 16'(DEPTH));
    read_bus(2, 1'b0, 16'h0, v); chk("status_full_ovf", v, 16'h0006);
    write_bus(3, 16'h0005, 1'b0, 16'h0);
    read_bus(2, 1'b0, 16'h0, v); chk("status_ovf_clr", v, 16'h0002);
    read_bus(3, 1'b0, 16'h0, v); chk("ctrl_still_on", v, 16'h0001);

    // Push and pop on the same edge while full
    read_bus(0, 1'b1, 16'h0200, v); chk("data_pop_push", v, 16'h0100);
    read_bus(1, 1'b0, 16'h0, v); chk("level_pop_push", v, 16'(DEPTH));
    read_bus(2, 1'b0, 16'h0, v); chk("status_pop_push", v, 16'h0002);

    // ovf_clr against a simultaneous overflow: set wins
    write_bus(3, 16'h0005, 1'b1, 16'h0300);
    read_bus(2, 1'b0, 16'h0, v); chk("status_set_wins", v, 16'h0006);

    // Flush against a simultaneous push: flush wins
    write_bus(3, 16'h0003, 1'b1, 16'h0400);
    read_bus(1, 1'b0, 16'h0, v); chk("level_flush", v, 16'h0000);
    read_bus(2, 1'b0, 16'h0, v); chk("status_flush", v, 16'h0005);
    write_bus(3, 16'h0005, 1'b0, 16'h0);
    read_bus(2, 1'b0, 16'h0, v); chk("status_clr2", v, 16'h0001);

    // Scratch and unmapped addresses
    write_bus(5, 16'h1234, 1'b0, 16'h0);
    read_bus(5, 1'b0, 16'h0, v); chk("scratch", v, scr_exp);
    write_bus(9, 16'hFFFF, 1'b0, 16'h0);
    read_bus(9, 1'b0, 16'h0, v); chk("unmapped", v, 16'h0000);
    read_bus(3, 1'b0, 16'h0, v); chk("ctrl_after_unmapped_wr", v, 16'h0001);
    push_word(16'h0555);
    push_word(16'h0666);

    // Reset in the middle of a read
    mdl_on   = 1'b0;
    fsmc_a   = ADDR_W'(4);
    fsmc_ne  = 1'b0;
    fsmc_noe = 1'b0;
    tick(4);
    chk("mid_read_oe", 16'(fsmc_db_oe), 16'h0001);
    chk("mid_read_db_o", fsmc_db_o, 16'h23A5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_db_oe", 16'(fsmc_db_oe), 16'h0);
    chk("async_rst_db_o", fsmc_db_o, 16'h0);
    chk("async_rst_capture_en", 16'(capture_en), 16'h0);
    chk("async_rst_fifo_ovf", 16'(fifo_ovf), 16'h0);
    model_reset();
    fsmc_ne  = 1'b1;
    fsmc_noe = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    mdl_on = 1'b1;

    read_bus(1, 1'b0, 16'h0, v); chk("level_after_rst", v, 16'h0000);
    read_bus(5, 1'b0, 16'h0, v); chk("scratch_after_rst", v, 16'h0000);
    write_bus(5, 16'h1234, 1'b0, 16'h0);
    read_bus(5, 1'b0, 16'h0, v); chk("scratch_after_rst_wr", v, scr_exp);

    mdl_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
